mem_arbiter: RTL and testbench

//   Shares one single-port unified memory between the fetch stage (instruction reads)
//   and the memory stage (data loads/stores) of the 5-stage pipeline.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_lat_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_e  - arbiter FSM encoding (IDLE=0 .. RESP=4, 3 bits)
//   grant_e      - which requester owns the current transaction
//   LAT_MAX      - largest supported memory read latency
//   CNT_W        - width of the latency counter, sized from LAT_MAX
//   pick_grant   - round-robin choice between fetch and data requests
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    // On a tie the port that did not win last time gets the memory.
    function automatic grant_e pick_grant(input logic if_req, input logic dm_req,
                                          input grant_e last);
        if (if_req && dm_req)
            return (last == GNT_IF) ? GNT_DM : GNT_IF;
        else if (dm_req)
            return GNT_DM;
        else
            return GNT_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// arb_lat_counter: loadable down-counter timing the memory read latency.
//   clk, rst    - clock, asynchronous active-high reset
//   load_i      - load load_val_i this cycle (arbiter leaving ISSUE)
//   load_val_i  - start value, LAT-1
//   done_o      - high while the count is 1 (last WAIT cycle)
// The counter free-runs down to 0 and parks there until the next load.
module arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port fixed-latency memory between the fetch
// stage and the memory stage. One transaction at a time:
// IDLE -> ISSUE -> WAIT x (LAT-1) -> CAPT -> RESP, then back to IDLE.
//   clk, rst                     - clock, asynchronous active-high reset
//   if_req/if_addr               - fetch read request (level) and byte address
//   if_rdata/if_ready            - fetched word and its one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata- data request (level), store flag, address, store data
//   dm_rdata/dm_ready            - load data (0 after a store) and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata - memory strobe (one cycle), write enable,
//                                  word address and write data
//   mem_rdata                    - memory read data, valid LAT cycles after mem_en
//   dbg_state_o                  - current FSM state
// Handshake: a requester raises req with addr/we/wdata and holds them until its
// ready pulse; the arbiter latches them at grant and ignores later changes. A req
// still high in the cycle after ready is a new request. All outputs are registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    dbg_state_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

    arb_state_e    state_q;
    grant_e        gnt_q;
    grant_e        last_gnt_q;
    grant_e        gnt_d;
    logic          we_q;
    logic [AW-3:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          if_ready_q;
    logic          dm_ready_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          cnt_done;

    // Byte-offset bits never reach the word-addressed memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

    assign gnt_d = pick_grant(if_req, dm_req, last_gnt_q);

    arb_lat_counter u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ISSUE),
        .load_val_i (LOAD_VAL),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            last_gnt_q <= GNT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            // Strobes and ready pulses are single-cycle by default.
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || dm_req) begin
                        gnt_q    <= gnt_d;
                        // mem_en is raised here so it is high exactly during ISSUE.
                        mem_en_q <= 1'b1;
                        if (gnt_d == GNT_DM) begin
                            addr_q   <= dm_addr[AW-1:2];
                            we_q     <= dm_we;
                            wdata_q  <= dm_wdata;
                            mem_we_q <= dm_we;
                        end else begin
                            addr_q   <= if_addr[AW-1:2];
                            we_q     <= 1'b0;
                            wdata_q  <= '0;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= (LAT == 1) ? CAPT : WAIT;
                WAIT: begin
                    if (cnt_done)
                        state_q <= CAPT;
                end
                CAPT: begin
                    // Stores return zero; only the granted port's buffer changes.
                    if (gnt_q == GNT_DM) begin
                        dm_rdata_q <= we_q ? '0 : mem_rdata;
                        dm_ready_q <= 1'b1;
                    end else begin
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    last_gnt_q <= gnt_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_ready    = if_ready_q;
    assign dm_ready    = dm_ready_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three builds (LAT=2, 1, 15) share the request inputs,
// each with its own fixed-latency memory model. Directed steps in one initial block.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;

    logic [31:0] if_rdata_w  [3];
    logic [31:0] dm_rdata_w  [3];
    logic [31:0] mem_wdata_w [3];
    logic [31:0] mem_rdata_w [3];
    logic [29:0] mem_addr_w  [3];
    logic [2:0]  state_w     [3];
    logic        if_ready_w  [3];
    logic        dm_ready_w  [3];
    logic        mem_en_w    [3];
    logic        mem_we_w    [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        if (i == 8'h10) return 32'h8C22_0004;
        return 32'hA500_0000 | {24'h0, i};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [31:0] mem    [256];
        logic [31:0] pipe_d [L];
        logic        pipe_v [L];

        mem_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .if_req      (if_req),
            .if_addr     (if_addr),
            .if_rdata    (if_rdata_w[g]),
            .if_ready    (if_ready_w[g]),
            .dm_req      (dm_req),
            .dm_we       (dm_we),
            .dm_addr     (dm_addr),
            .dm_wdata    (dm_wdata),
            .dm_rdata    (dm_rdata_w[g]),
            .dm_ready    (dm_ready_w[g]),
            .mem_en      (mem_en_w[g]),
            .mem_we      (mem_we_w[g]),
            .mem_addr    (mem_addr_w[g]),
            .mem_wdata   (mem_wdata_w[g]),
            .mem_rdata   (mem_rdata_w[g]),
            .dbg_state_o (state_w[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(8'(i));
            for (int k = 0; k < L; k++) begin
                pipe_v[k] = 1'b0;
                pipe_d[k] = '0;
            end
        end

        // Read data appears exactly L cycles after the mem_en cycle; otherwise garbage.
        always @(posedge clk) begin
            if (mem_en_w[g] && mem_we_w[g]) mem[mem_addr_w[g][7:0]] <= mem_wdata_w[g];
            pipe_v[0] <= mem_en_w[g] && !mem_we_w[g];
            pipe_d[0] <= mem[mem_addr_w[g][7:0]];
            for (int k = 1; k < L; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end

        assign mem_rdata_w[g] = pipe_v[L-1] ? pipe_d[L-1] : 32'hBAD0_BAD0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // n counts cycles inclusively from the cycle the request is first visible.
    task automatic watch(input int idx, input bit is_dm, input int max_n, output int n,
                         output int en_cnt, output logic [29:0] a_seen, output logic we_seen,
                         output logic [31:0] wd_seen, output int other_rdy);
        n = 1; en_cnt = 0; a_seen = '0; we_seen = 1'b0; wd_seen = '0; other_rdy = 0;
        while (n <= max_n) begin
            step();
            n++;
            if (mem_en_w[idx]) begin
                en_cnt++;
                a_seen  = mem_addr_w[idx];
                we_seen = mem_we_w[idx];
                wd_seen = mem_wdata_w[idx];
            end
            if (is_dm ? if_ready_w[idx] : dm_ready_w[idx]) other_rdy++;
            if (is_dm ? dm_ready_w[idx] : if_ready_w[idx]) break;
        end
    endtask

    initial begin
        int          n, en, oth, stale;
        logic [29:0] a;
        logic        w;
        logic [31:0] wd;
        logic        exp_dm;
        int          first [3];
        logic [31:0] rd    [3];

        // Reset held with both requests pending.
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        if_addr = 32'h80; dm_addr = 32'hC0; dm_wdata = '0;
        repeat (3) step();
        chk("rst_mem_en",   32'(mem_en_w[0]),   32'd0);
        chk("rst_if_ready", 32'(if_ready_w[0]), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready_w[0]), 32'd0);
        chk("rst_state",    32'(state_w[0]),    32'd0);

        // First tie after reset goes to data.
        rst = 1'b0;
        watch(0, 1'b1, 12, n, en, a, w, wd, oth);
        chk("tie0_latency", n, 5);
        chk("tie0_en_cnt",  en, 1);
        chk("tie0_addr",    32'(a), 32'h30);
        chk("tie0_if_rdy",  oth, 0);
        chk("tie0_rdata",   dm_rdata_w[0], 32'hA500_0030);
        if_req = 1'b0; dm_req = 1'b0;
        step();
        chk("tie0_pulse_w", 32'(dm_ready_w[0]), 32'd0);

        // Store.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        watch(0, 1'b1, 12, n, en, a, w, wd, oth);
        chk("st_latency", n, 5);
        chk("st_en_cnt",  en, 1);
        chk("st_addr",    32'(a), 32'h40);
        chk("st_we",      32'(w), 32'd1);
        chk("st_wdata",   wd, 32'hDEAD_BEEF);
        chk("st_rdata",   dm_rdata_w[0], 32'h0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();

        // Load back the stored word.
        dm_req = 1'b1;
        watch(0, 1'b1, 12, n, en, a, w, wd, oth);
        chk("ld_we",    32'(w), 32'd0);
        chk("ld_rdata", dm_rdata_w[0], 32'hDEAD_BEEF);
        dm_req = 1'b0;
        step();

        // Lone fetch.
        if_req = 1'b1; if_addr = 32'h40;
        watch(0, 1'b0, 12, n, en, a, w, wd, oth);
        chk("if_latency", n, 5);
        chk("if_en_cnt",  en, 1);
        chk("if_addr",    32'(a), 32'h10);
        chk("if_dm_rdy",  oth, 0);
        chk("if_rdata",   if_rdata_w[0], 32'h8C22_0004);
        if_req = 1'b0;
        step();
        chk("if_pulse_w",  32'(if_ready_w[0]), 32'd0);
        chk("if_hold",     if_rdata_w[0], 32'h8C22_0004);
        chk("dm_hold",     dm_rdata_w[0], 32'hDEAD_BEEF);

        // Contention: last grant was fetch, so DM, IF, DM, IF.
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_addr = 32'h48; dm_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_dm = (t % 2 == 0);
            n = 0;
            while (n < 12 && !(if_ready_w[0] || dm_ready_w[0])) begin
                step();
                n++;
            end
            chk("ctn_dm_ready", 32'(dm_ready_w[0]), 32'(exp_dm));
            chk("ctn_if_ready", 32'(if_ready_w[0]), 32'(!exp_dm));
            if (exp_dm) chk("ctn_dm_rdata", dm_rdata_w[0], 32'hA500_0012);
            else        chk("ctn_if_rdata", if_rdata_w[0], 32'hA500_0011);
            step();
            chk("ctn_pulse_w", 32'({if_ready_w[0], dm_ready_w[0]}), 32'd0);
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) step();

        // Asynchronous reset in the middle of WAIT.
        if_req = 1'b1; if_addr = 32'h4C;
        step();
        chk("ar_issue", 32'(state_w[0]), 32'd1);
        step();
        chk("ar_wait",  32'(state_w[0]), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_mem_en",   32'(mem_en_w[0]),   32'd0);
        chk("ar_state",    32'(state_w[0]),    32'd0);
        chk("ar_if_rdata", if_rdata_w[0],      32'd0);
        chk("ar_dm_rdata", dm_rdata_w[0],      32'd0);
        if_req = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        stale = 0;
        repeat (20) begin
            step();
            if (if_ready_w[0] || dm_ready_w[0]) stale++;
        end
        chk("ar_no_stale", stale, 0);
        if_req = 1'b1;
        watch(0, 1'b0, 12, n, en, a, w, wd, oth);
        chk("ar_latency", n, 5);
        chk("ar_rdata",   if_rdata_w[0], 32'hA500_0013);
        if_req = 1'b0;

        // Lone load on all three latency builds from a clean reset.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        dm_req = 1'b1; dm_addr = 32'h50; dm_we = 1'b0;
        first = '{0, 0, 0};
        rd    = '{32'h0, 32'h0, 32'h0};
        n = 1;
        while (n < 25 && (first[0] == 0 || first[1] == 0 || first[2] == 0)) begin
            step();
            n++;
            for (int k = 0; k < 3; k++) begin
                if (first[k] == 0 && dm_ready_w[k]) begin
                    first[k] = n;
                    rd[k]    = dm_rdata_w[k];
                end
            end
        end
        dm_req = 1'b0;
        chk("lat2_cycles",  first[0], 5);
        chk("lat1_cycles",  first[1], 4);
        chk("lat15_cycles", first[2], 18);
        chk("lat2_rdata",   rd[0], 32'hA500_0014);
        chk("lat1_rdata",   rd[1], 32'hA500_0014);
        chk("lat15_rdata",  rd[2], 32'hA500_0014);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
